// File: rtl/pixel_frame_buffer_if.sv
// Push/pop strobe bus between the median-filter sequencer (master) and the
// pixel frame buffer (slave), including occupancy, flags and raster position.
interface pixel_frame_buffer_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
);
  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic [ADDR_W-1:0] out_col;
  logic [ADDR_W-1:0] out_row;
  logic              frame_done;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, data_in,
    input  data_out, out_valid, out_col, out_row, frame_done,
    input  count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, out_valid, out_col, out_row, frame_done,
    output count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pixel_frame_buffer.sv
// One-frame pixel store replayed in raster order with occupancy, sticky error flags
// and end-of-frame pulse. Optional PIXEL_FRAME_BUFFER_BYPASS_EN forwards push->pop when empty.
module pixel_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  pixel_frame_buffer_if.slave    bus
);
  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
  logic [ADDR_W-1:0] nxt_col_q, nxt_col_d, nxt_row_q, nxt_row_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              push_ok, pop_ok, bypass, load;

  always_comb begin
`ifdef PIXEL_FRAME_BUFFER_BYPASS_EN
    bypass = bus.push && bus.pop && empty_q;
`else
    bypass = 1'b0;
`endif
    pop_ok  = bus.pop && !empty_q;
    // A full buffer still accepts a push when a pop frees the slot in the same cycle.
    push_ok = bus.push && !bypass && (!full_q || pop_ok);
    load    = pop_ok || bypass;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    out_valid_d  = load;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    nxt_col_d    = nxt_col_q;
    nxt_row_d    = nxt_row_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (bus.push && !push_ok && !bypass);
    underflow_d  = underflow_q | (bus.pop && !pop_ok && !bypass);

    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d   = (rd_ptr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : rd_ptr_q + 1'b1;
      data_out_d = mem[rd_ptr_q];
    end else if (bypass) begin
      data_out_d = bus.data_in;
    end else begin
      data_out_d = data_out_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == {(ADDR_W + 1){1'b0}});

    // nxt_* holds the raster position the next delivered pixel will carry.
    if (load) begin
      out_col_d    = nxt_col_q;
      out_row_d    = nxt_row_q;
      frame_done_d = (nxt_col_q == LAST_COL) && (nxt_row_q == LAST_ROW);
      if (nxt_col_q == LAST_COL) begin
        nxt_col_d = {ADDR_W{1'b0}};
        nxt_row_d = (nxt_row_q == LAST_ROW) ? {ADDR_W{1'b0}} : nxt_row_q + 1'b1;
      end else begin
        nxt_col_d = nxt_col_q + 1'b1;
        nxt_row_d = nxt_row_q;
      end
    end else begin
      nxt_col_d = nxt_col_q;
      nxt_row_d = nxt_row_q;
    end
  end

  // Pixel storage is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= {ADDR_W{1'b0}};
      rd_ptr_q     <= {ADDR_W{1'b0}};
      count_q      <= {(ADDR_W + 1){1'b0}};
      data_out_q   <= {DATA_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_col_q    <= {ADDR_W{1'b0}};
      out_row_q    <= {ADDR_W{1'b0}};
      nxt_col_q    <= {ADDR_W{1'b0}};
      nxt_row_q    <= {ADDR_W{1'b0}};
      frame_done_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      nxt_col_q    <= nxt_col_d;
      nxt_row_q    <= nxt_row_d;
      frame_done_q <= frame_done_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_row    = out_row_q;
  assign bus.frame_done = frame_done_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Randomized and directed bench for pixel_frame_buffer (4x4 frame) against a
// queue-based reference model with pixel-index raster arithmetic.
module tb_pixel_frame_buffer;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int DEPTH  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_frame_buffer_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  pixel_frame_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q [$];
  logic [7:0] m_data;
  logic       m_valid, m_fd, m_ovf, m_unf;
  int         m_col, m_row, m_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    else n_pass++;
  endtask

  task automatic compare_all();
    check_val("out_valid",  32'(bus.out_valid),  32'(m_valid));
    check_val("data_out",   32'(bus.data_out),   32'(m_data));
    check_val("out_col",    32'(bus.out_col),    m_col);
    check_val("out_row",    32'(bus.out_row),    m_row);
    check_val("frame_done", 32'(bus.frame_done), 32'(m_fd));
    check_val("count",      32'(bus.count),      q.size());
    check_val("full",       32'(bus.full),       32'(q.size() == DEPTH));
    check_val("empty",      32'(bus.empty),      32'(q.size() == 0));
    check_val("overflow",   32'(bus.overflow),   32'(m_ovf));
    check_val("underflow",  32'(bus.underflow),  32'(m_unf));
  endtask

  task automatic do_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 8'h00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    m_data = 8'h00; m_valid = 1'b0; m_fd = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_col = 0; m_row = 0; m_idx = 0;
    compare_all();
  endtask

  task automatic step(input logic p, input logic pp, input logic [7:0] d);
    logic empty_now, full_now, byp, pop_ok, push_ok;
    bus.push = p; bus.pop = pp; bus.data_in = d;
    @(posedge clk); #1;
    empty_now = (q.size() == 0);
    full_now  = (q.size() == DEPTH);
`ifdef PIXEL_FRAME_BUFFER_BYPASS_EN
    byp = p && pp && empty_now;
`else
    byp = 1'b0;
`endif
    pop_ok  = pp && !empty_now;
    push_ok = p && !byp && (!full_now || pop_ok);
    if (p && !push_ok && !byp) m_ovf = 1'b1;
    if (pp && !pop_ok && !byp) m_unf = 1'b1;
    m_valid = pop_ok || byp;
    if (byp) m_data = d;
    else if (pop_ok) m_data = q.pop_front();
    if (push_ok) q.push_back(d);
    if (m_valid) begin
      m_col = m_idx % IMG_W;
      m_row = m_idx / IMG_W;
      m_fd  = (m_idx == DEPTH - 1);
      m_idx = (m_idx + 1) % DEPTH;
    end else begin
      m_fd = 1'b0;
    end
    compare_all();
  endtask

  initial begin
    int push_pct;
    do_reset();
    do_reset();

    // Pop on empty: underflow sticks across idle cycles.
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

    // Fill, overflow attempt, full drain with raster/frame_done.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    check_val("full_after_fill", 32'(bus.full), 32'd1);
    step(1'b1, 1'b0, 8'hAA);
    check_val("overflow_17th", 32'(bus.overflow), 32'd1);
    step(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, 8'h00);
    check_val("empty_after_drain", 32'(bus.empty), 32'd1);

    // Reset mid-frame, then a single pixel lands at (0,0).
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
    do_reset();
    step(1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 8'h00);
    check_val("reset_refill_data", 32'(bus.data_out), 32'h55);

    // Simultaneous push/pop on empty.
    do_reset();
    step(1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 8'h00);

    // Randomized traffic alternating fill-biased and drain-biased phases.
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      push_pct = ((i / 60) % 2 == 0) ? 85 : 25;
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(1'($urandom_range(0, 99) < push_pct),
                1'($urandom_range(0, 99) >= push_pct - 10),
                8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
